stopwatch: RTL and testbench

STOPWATCH -- requirements
Module: stopwatch

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/seg7_dec.sv | 19 +
 rtl/stopwatch.sv | 144 ++++++++++++++
 tb/tb_stopwatch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch block.
//   state_t   : FSM encoding (BLANK after reset, RUN, STOP)
//   SEG_TBL   : BCD digit -> active-low segment code {DP,g,f,e,d,c,b,a}, DP off
//   SEG_BLANK : all segments off
//   dig_max() : highest legal value of each BCD digit of the count
package stopwatch_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2
  } state_t;

  localparam int NUM_DIG = 6;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry [n] is the code for digit n.
  localparam logic [9:0][7:0] SEG_TBL = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                         8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

  // Digit order: 0 cs ones, 1 cs tens, 2 s ones, 3 s tens, 4 m ones, 5 m tens.
  // Tens of seconds and tens of minutes roll over after 5.
  function automatic logic [3:0] dig_max(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder (active-low).
//   bcd   : digit value 0-9 (10-15 decode to blank)
//   dp_on : light the decimal point (bit 7 driven low)
//   seg   : segments {DP,g,f,e,d,c,b,a}
module seg7_dec
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp_on,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TBL[bcd];
    if (dp_on)       seg[7] = 1'b0;
  end

endmodule

// File: rtl/stopwatch.sv
// Stopwatch mm:ss.cc with start/stop button, clear pulse and wrap flag.
//   CLK1      : single system clock
//   RST_N     : synchronous active-low reset
//   BTN_SS_N  : asynchronous active-low start/stop button
//   CLEAR     : 1-cycle synchronous clear of count, prescaler and OVF
//   HEX0..5   : registered active-low segments; HEX1:0 cs, HEX3:2 s, HEX5:4 min
//   RUNNING   : high while counting
//   OVF       : sticky, set when the count wraps past 59:59.99
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int P_CLK_FREQ = 50_000_000,
  parameter int P_TICK_HZ  = 100
) (
  input  logic       CLK1,
  input  logic       RST_N,
  input  logic       BTN_SS_N,
  input  logic       CLEAR,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic       RUNNING,
  output logic       OVF
);

  localparam int DIV = P_CLK_FREQ / P_TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  state_t                        state, state_nxt;
  logic                          s1, s2, s3;
  logic [1:0]                    vld_pipe;
  logic                          armed, ev_q;
  logic [PW-1:0]                 presc, presc_nxt;
  logic                          tick, wrap;
  logic [NUM_DIG-1:0][3:0]       cnt, cnt_inc, cnt_nxt;
  logic                          ovf_q, ovf_nxt;
  logic [NUM_DIG-1:0][7:0]       seg, hex_q;

  // Button path: s1/s2 synchronize, s3 is the previous s2 for edge detect.
  // vld_pipe marks when s2 holds a real sample after reset; the detector is
  // only armed once the button has been seen released, so a button held
  // through reset never counts as a press.
  always_ff @(posedge CLK1) begin
    if (!RST_N) begin
      {s1, s2, s3} <= 3'b111;
      vld_pipe     <= '0;
      armed        <= 1'b0;
      ev_q         <= 1'b0;
    end else begin
      s1       <= BTN_SS_N;
      s2       <= s1;
      s3       <= s2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      armed    <= armed | (vld_pipe[1] & s2);
      ev_q     <= armed & s3 & ~s2;
    end
  end

  assign tick = (state == RUN) && (presc == PW'(DIV - 1));

  // BCD increment with ripple carry; wrap is the carry out of the top digit.
  always_comb begin
    cnt_inc = cnt;
    wrap    = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (wrap) begin
        if (cnt[i] == dig_max(i)) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt[i] + 4'd1;
          wrap       = 1'b0;
        end
      end
    end
  end

  // Clear wins over a same-cycle tick; the start/stop event is applied to
  // the post-clear state so BLANK+CLEAR+event lands in RUN.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_q;
    if (CLEAR) begin
      presc_nxt = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      if (state == BLANK) state_nxt = STOP;
    end else begin
      if (state == RUN) presc_nxt = tick ? '0 : presc + PW'(1);
      if (tick) begin
        cnt_nxt = cnt_inc;
        ovf_nxt = ovf_q | wrap;
      end
    end
    if (ev_q) begin
      case (state_nxt)
        BLANK, STOP: state_nxt = RUN;
        RUN:         state_nxt = STOP;
        default:     state_nxt = BLANK;
      endcase
    end
  end

  always_ff @(posedge CLK1) begin
    if (!RST_N) begin
      state <= BLANK;
      presc <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    seg7_dec u_dec (
      .bcd   (cnt[i]),
      .dp_on (i == 2 || i == 4),
      .seg   (seg[i])
    );
  end

  always_ff @(posedge CLK1) begin
    if (!RST_N) hex_q <= {NUM_DIG{SEG_BLANK}};
    else        hex_q <= (state == BLANK) ? {NUM_DIG{SEG_BLANK}} : seg;
  end

  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign HEX4    = hex_q[4];
  assign HEX5    = hex_q[5];
  assign RUNNING = (state == RUN);
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch: 1 kHz clock (1 ms period), 100 Hz tick,
// so one tick is 10 cycles and 10**7 ns.
`timescale 1ns/1ns
module tb_stopwatch;

  logic        CLK1 = 1'b0;
  logic        RST_N = 1'b0;
  logic        BTN_SS_N = 1'b1;
  logic        CLEAR = 1'b0;
  logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        RUNNING, OVF;
  logic [47:0] hexv;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [47:0] HEX_BLANK = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] HEX_ZERO  = 48'hC0_40_C0_40_C0_C0;

  stopwatch #(.P_CLK_FREQ(1000), .P_TICK_HZ(100)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .BTN_SS_N(BTN_SS_N), .CLEAR(CLEAR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .RUNNING(RUNNING), .OVF(OVF)
  );

  assign hexv = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #500_000 CLK1 = ~CLK1;

  // One-cycle press; returns at the negedge after the sampling edge e0.
  task automatic press();
    @(negedge CLK1) BTN_SS_N = 1'b0;
    @(posedge CLK1);
    @(negedge CLK1) BTN_SS_N = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge CLK1) CLEAR = 1'b1;
    @(posedge CLK1);
    @(negedge CLK1) CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (5) @(posedge CLK1);
    @(negedge CLK1) RST_N = 1'b1;
    repeat (20) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (hexv !== HEX_BLANK) begin n_bad++; $display("FAIL reset_hex got %h exp %h", hexv, HEX_BLANK); end
    n_cmp++; if (RUNNING !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b exp 0", RUNNING); end
    n_cmp++; if (OVF !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b exp 0", OVF); end
  endtask

  // 1000 RUN cycles = 100 ticks = 00:01.00; RUNNING rises 3 edges after e0.
  task automatic test_run_1s();
    press();
    repeat (2) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (RUNNING !== 1'b0) begin n_bad++; $display("FAIL latency_early got %b exp 0", RUNNING); end
    @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (RUNNING !== 1'b1) begin n_bad++; $display("FAIL latency_run got %b exp 1", RUNNING); end
    repeat (996) @(posedge CLK1);
    press();
    repeat (10) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (RUNNING !== 1'b0) begin n_bad++; $display("FAIL run1s_stopped got %b exp 0", RUNNING); end
    n_cmp++; if (hexv !== 48'hC0_40_C0_79_C0_C0) begin n_bad++; $display("FAIL run1s_hex got %h exp %h", hexv, 48'hC0_40_C0_79_C0_C0); end
  endtask

  // 35 RUN cycles -> 3 ticks, prescaler held at 5; 5 more -> 4th tick.
  task automatic test_prescaler_hold();
    pulse_clear();
    @(negedge CLK1);
    n_cmp++; if (hexv !== HEX_ZERO) begin n_bad++; $display("FAIL clear_hex got %h exp %h", hexv, HEX_ZERO); end
    press();
    repeat (34) @(posedge CLK1);
    press();
    repeat (100) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (HEX0 !== 8'hB0) begin n_bad++; $display("FAIL hold_hex0_3 got %h exp b0", HEX0); end
    press();
    repeat (4) @(posedge CLK1);
    press();
    repeat (10) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (HEX0 !== 8'h99) begin n_bad++; $display("FAIL resume_hex0_4 got %h exp 99", HEX0); end
    n_cmp++; if (HEX1 !== 8'hC0) begin n_bad++; $display("FAIL resume_hex1 got %h exp c0", HEX1); end
  endtask

  // Preload 59:59.99 in STOP, run one tick, then time HEX0 changes.
  task automatic test_overflow();
    time t0, t1;
    int  nchg;
    logic [7:0] prev;
    pulse_clear();
    force dut.cnt = 24'h595999;
    repeat (2) @(posedge CLK1);
    @(negedge CLK1) release dut.cnt;
    n_cmp++; if (hexv !== 48'h92_10_92_10_90_90) begin n_bad++; $display("FAIL preload_max got %h exp %h", hexv, 48'h92_10_92_10_90_90); end
    press();
    repeat (14) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (hexv !== HEX_ZERO) begin n_bad++; $display("FAIL wrap_hex got %h exp %h", hexv, HEX_ZERO); end
    n_cmp++; if (OVF !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf got %b exp 1", OVF); end
    n_cmp++; if (RUNNING !== 1'b1) begin n_bad++; $display("FAIL wrap_running got %b exp 1", RUNNING); end
    prev = HEX0; nchg = 0; t0 = 0; t1 = 0;
    for (int k = 0; k < 40 && nchg < 2; k++) begin
      @(negedge CLK1);
      if (HEX0 !== prev) begin
        if (nchg == 0) t0 = $time; else t1 = $time;
        nchg++;
        prev = HEX0;
      end
    end
    n_cmp++; if (nchg != 2 || (t1 - t0) != 64'd10_000_000) begin n_bad++; $display("FAIL tick_interval got %0d ns (%0d changes) exp 10000000 ns", t1 - t0, nchg); end
    press();
    repeat (10) @(posedge CLK1);
  endtask

  // CLEAR coincident with the registered event while STOP at 00:02.50.
  task automatic test_clear_event();
    force dut.cnt = 24'h000250;
    repeat (2) @(posedge CLK1);
    @(negedge CLK1) release dut.cnt;
    n_cmp++; if (hexv !== 48'hC0_40_C0_24_92_C0) begin n_bad++; $display("FAIL preload_250 got %h exp %h", hexv, 48'hC0_40_C0_24_92_C0); end
    n_cmp++; if (OVF !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b exp 1", OVF); end
    @(negedge CLK1) BTN_SS_N = 1'b0;
    @(posedge CLK1);
    @(negedge CLK1) BTN_SS_N = 1'b1;
    repeat (2) @(posedge CLK1);
    @(negedge CLK1) CLEAR = 1'b1;
    @(posedge CLK1);
    @(negedge CLK1) CLEAR = 1'b0;
    n_cmp++; if (RUNNING !== 1'b1) begin n_bad++; $display("FAIL clr_ev_running got %b exp 1", RUNNING); end
    n_cmp++; if (OVF !== 1'b0) begin n_bad++; $display("FAIL clr_ev_ovf got %b exp 0", OVF); end
    @(negedge CLK1);
    n_cmp++; if (hexv !== HEX_ZERO) begin n_bad++; $display("FAIL clr_ev_hex got %h exp %h", hexv, HEX_ZERO); end
  endtask

  // Reset mid-run with the button held low: must land in BLANK and stay there.
  task automatic test_reset_held();
    @(negedge CLK1) begin RST_N = 1'b0; BTN_SS_N = 1'b0; end
    repeat (3) @(posedge CLK1);
    @(negedge CLK1) RST_N = 1'b1;
    repeat (20) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (RUNNING !== 1'b0) begin n_bad++; $display("FAIL held_running got %b exp 0", RUNNING); end
    n_cmp++; if (hexv !== HEX_BLANK) begin n_bad++; $display("FAIL held_hex got %h exp %h", hexv, HEX_BLANK); end
    n_cmp++; if (OVF !== 1'b0) begin n_bad++; $display("FAIL held_ovf got %b exp 0", OVF); end
    BTN_SS_N = 1'b1;
    repeat (5) @(posedge CLK1);
    press();
    repeat (4) @(posedge CLK1);
    @(negedge CLK1);
    n_cmp++; if (RUNNING !== 1'b1) begin n_bad++; $display("FAIL repress_running got %b exp 1", RUNNING); end
  endtask

  initial begin
    test_reset();
    test_run_1s();
    test_prescaler_hold();
    test_overflow();
    test_clear_event();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
